// File: rtl/rr_encode_arbiter.sv
// Round-robin arbiter for 2**N requesters: rotated priority-encode selection,
// grant/done ownership handshake and a hold-timeout watchdog.
module rr_encode_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [2**N-1:0]   req,
    input  logic              done,
    output logic [2**N-1:0]   grant,
    output logic [N-1:0]      encode,
    output logic              grant_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int REQ_W = 2**N;
    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REQ_W-1:0] r_grant;
    logic [REQ_W-1:0] w_grant_nxt;
    logic [N-1:0]     r_encode;
    logic [N-1:0]     w_encode_nxt;
    logic [N-1:0]     r_ptr;
    logic [N-1:0]     w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_timeout;
    logic             w_timeout_nxt;

    logic [REQ_W-1:0] w_masked;
    logic [N-1:0]     w_winner;
    logic             w_owner_req;
    logic             w_hold_expired;

    function automatic logic [N-1:0] lowest_set(input logic [REQ_W-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (v[i]) idx = N'(i);
        end
        return idx;
    endfunction

    function automatic logic [REQ_W-1:0] upper_mask(input logic [N-1:0] p);
        logic [REQ_W-1:0] m;
        m = '0;
        for (int i = 0; i < REQ_W; i++) begin
            m[i] = (i >= int'(p));
        end
        return m;
    endfunction

    // Requests at or above the pointer take priority; fall back to the full
    // request vector so lower indices are served once the top is exhausted.
    always_comb begin
        w_masked = req & upper_mask(r_ptr);
        if (|w_masked) w_winner = lowest_set(w_masked);
        else           w_winner = lowest_set(req);
    end

    assign w_owner_req    = req[r_encode];
    assign w_hold_expired = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_encode_nxt   = r_encode;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && (|req)) begin
                    w_state_nxt    = S_GRANT;
                    w_encode_nxt   = w_winner;
                    w_grant_nxt    = {{(REQ_W-1){1'b0}}, 1'b1} << w_winner;
                    w_hold_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                // A normal release (done or withdrawal) masks a coincident timeout.
                if (done || !w_owner_req || w_hold_expired) begin
                    w_state_nxt    = S_RELEASE;
                    w_grant_nxt    = '0;
                    w_ptr_nxt      = r_encode + N'(1);
                    w_hold_cnt_nxt = '0;
                    w_timeout_nxt  = !(done || !w_owner_req);
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_encode   <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_encode   <= w_encode_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign encode      = r_encode;
    assign grant_valid = (r_state == S_GRANT);
    assign busy        = (r_state != S_IDLE);
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_encode_arbiter.sv
// Directed bench for rr_encode_arbiter (N=3, MAX_HOLD=16) with hand-computed
// expectations for reset, rotation, handshake, timeout, withdrawal and reset.
module tb_rr_encode_arbiter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] encode;
    logic       grant_valid;
    logic       timeout;
    logic       busy;

    int n_checks;
    int n_fail;
    int hold_cycles;

    rr_encode_arbiter #(.N(3), .MAX_HOLD(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .encode      (encode),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'h0);
        check({tag, ".encode"}, 32'(encode), 32'h0);
        check({tag, ".gv"}, 32'(grant_valid), 32'h0);
        check({tag, ".timeout"}, 32'(timeout), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        req      = 8'hFF;
        done     = 1'b0;

        // Reset and idle with enable low.
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset_idle");
        check("reset_ptr", 32'(dut.r_ptr), 32'd0);

        // Single requester 4.
        req    = 8'b0001_0000;
        enable = 1'b1;
        tick();
        check("single.encode", 32'(encode), 32'd4);
        check("single.grant", 32'(grant), 32'h10);
        check("single.gv", 32'(grant_valid), 32'd1);
        check("single.busy", 32'(busy), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        check("single_rel.gv", 32'(grant_valid), 32'd0);
        check("single_rel.grant", 32'(grant), 32'h0);
        check("single_rel.busy", 32'(busy), 32'd1);
        check("single_rel.ptr", 32'(dut.r_ptr), 32'd5);
        tick();
        check("single_idle.busy", 32'(busy), 32'd0);

        // Round-robin over all requesters from ptr=0, including wrap to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_reset.ptr", 32'(dut.r_ptr), 32'd0);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("rr%0d.encode", k), 32'(encode), 32'(k % 8));
            check($sformatf("rr%0d.grant", k), 32'(grant), 32'h1 << (k % 8));
            check($sformatf("rr%0d.gv", k), 32'(grant_valid), 32'd1);
            tick();
            check($sformatf("rr%0d.hold", k), 32'(grant_valid), 32'd1);
            done = 1'b1;
            tick();
            done = 1'b0;
            check($sformatf("rr%0d.rel_gv", k), 32'(grant_valid), 32'd0);
            check($sformatf("rr%0d.rel_busy", k), 32'(busy), 32'd1);
            tick();
            check($sformatf("rr%0d.idle_gv", k), 32'(grant_valid), 32'd0);
            check($sformatf("rr%0d.idle_busy", k), 32'(busy), 32'd0);
        end

        // Rotation past the pointer: grant 5 to move ptr to 6, then req 0x22 -> 1.
        req = 8'b0010_0000;
        tick();
        check("rot_setup.encode", 32'(encode), 32'd5);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'b0010_0010;
        tick();
        check("rot.ptr", 32'(dut.r_ptr), 32'd6);
        tick();
        check("rot.encode", 32'(encode), 32'd1);
        check("rot.grant", 32'(grant), 32'h02);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();

        // Timeout: requester 2 never releases; ptr is 2 here.
        req = 8'h04;
        tick();
        check("to.encode", 32'(encode), 32'd2);
        hold_cycles = 0;
        while (grant_valid && hold_cycles < 40) begin
            check("to.no_early_pulse", 32'(timeout), 32'd0);
            hold_cycles++;
            tick();
        end
        check("to.hold_cycles", 32'(hold_cycles), 32'd16);
        check("to.pulse", 32'(timeout), 32'd1);
        check("to.gv", 32'(grant_valid), 32'd0);
        check("to.busy", 32'(busy), 32'd1);
        check("to.ptr", 32'(dut.r_ptr), 32'd3);
        tick();
        check("to.pulse_one_cycle", 32'(timeout), 32'd0);

        // done on the same edge as the timeout: no pulse.
        tick();
        check("to_done.encode", 32'(encode), 32'd2);
        for (int i = 0; i < 15; i++) tick();
        check("to_done.still_held", 32'(grant_valid), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        check("to_done.timeout", 32'(timeout), 32'd0);
        check("to_done.gv", 32'(grant_valid), 32'd0);
        check("to_done.busy", 32'(busy), 32'd1);
        tick();

        // Withdrawal by owner 3.
        req = 8'h08;
        tick();
        check("wd.encode", 32'(encode), 32'd3);
        tick();
        check("wd.held", 32'(grant_valid), 32'd1);
        req = 8'h00;
        tick();
        check("wd.gv", 32'(grant_valid), 32'd0);
        check("wd.timeout", 32'(timeout), 32'd0);
        check("wd.busy", 32'(busy), 32'd1);
        check("wd.ptr", 32'(dut.r_ptr), 32'd4);
        tick();

        // done outside GRANT is ignored.
        done = 1'b1;
        tick();
        done = 1'b0;
        check("stray_done.busy", 32'(busy), 32'd0);

        // enable dropped during GRANT: current grant completes, no new one.
        req = 8'h01;
        tick();
        check("en.encode", 32'(encode), 32'd0);
        enable = 1'b0;
        tick();
        check("en.held", 32'(grant_valid), 32'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        tick();
        check("en.no_regrant", 32'(grant_valid), 32'd0);
        check("en.idle_busy", 32'(busy), 32'd0);
        enable = 1'b1;

        // Reset during GRANT.
        req = 8'h40;
        tick();
        check("mid_rst.encode_before", 32'(encode), 32'd6);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("mid_rst");
        check("mid_rst.ptr", 32'(dut.r_ptr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
